// File: rtl/pio_in_capture_if.sv
// Register-bus bundle for pio_in_capture: a single-cycle write strobe plus registered read data.
// The host drives through the master modport and the capture block answers through the slave modport.
interface pio_in_capture_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_in_capture.sv
// Parallel input port. It synchronises in_port, latches the selected edge type per bit,
// and raises an interrupt on masked captured edges (or on masked input levels).
module pio_in_capture #(
  parameter int WIDTH       = 8,  // 1..32
  parameter int SYNC_STAGES = 2,  // 2..3
  parameter int EDGE_TYPE   = 0,  // 0 rising, 1 falling, 2 any
  parameter int IRQ_MODE    = 1   // 0 level, 1 edge capture
) (
  input  logic              clk,
  input  logic              reset,
  pio_in_capture_if.slave   bus,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] data_sync;
  logic [WIDTH-1:0] data_prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] clear_bits;
  logic [31:0]      readdata_next;
  logic             write_en;

  // Only the low WIDTH bits of writedata carry register content.
  logic unused_writedata;
  assign unused_writedata = ^bus.writedata;

  assign data_sync = sync_q[SYNC_STAGES-1];
  assign write_en  = bus.chipselect & bus.write;

  // NOTE: registers update with non-blocking (<=) so every flop samples pre-edge values;
  // blocking assignments here would collapse the synchroniser chain into one stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      data_prev <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], in_port};
      data_prev <= data_sync;
    end
  end

  // NOTE: every always_comb output gets a default before the case so no latch is inferred.
  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = data_sync & ~data_prev;
      1:       edge_det = ~data_sync & data_prev;
      default: edge_det = data_sync ^ data_prev;
    endcase
  end

  assign clear_bits = (write_en && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

  // A fresh edge is ORed in after the clear, so a set and a clear in the same cycle leave the bit at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_capture <= '0;
      irq_mask     <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clear_bits) | edge_det;
      if (write_en && bus.address == ADDR_MASK) begin
        irq_mask <= bus.writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    readdata_next = '0;
    case (bus.address)
      ADDR_DATA: readdata_next[WIDTH-1:0] = data_sync;
      ADDR_MASK: readdata_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: readdata_next[WIDTH-1:0] = edge_capture;
      default:   readdata_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= readdata_next;
    end
  end

  // irq depends only on flops, so no bus input reaches it combinationally.
  generate
    if (IRQ_MODE == 1) begin : g_irq_edge
      assign irq = |(edge_capture & irq_mask);
    end else begin : g_irq_level
      assign irq = |(data_sync & irq_mask);
    end
  endgenerate

endmodule

// File: tb/tb_pio_in_capture.sv
// Directed bench for pio_in_capture: three instances cover the default configuration,
// a 32-bit any-edge port, and a level-sensitive interrupt port.
module tb_pio_in_capture;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_port0;
  logic [31:0] in_port1;
  logic [7:0]  in_port2;
  logic        irq0, irq1, irq2;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  pio_in_capture_if bus0 ();
  pio_in_capture_if bus1 ();
  pio_in_capture_if bus2 ();

  pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .in_port(in_port0), .irq(irq0));
  pio_in_capture #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .in_port(in_port1), .irq(irq1));
  pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(0)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .in_port(in_port2), .irq(irq2));

  // Inputs change and outputs are sampled on the falling edge; each step crosses one rising edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_idle();
    bus0.chipselect = 1'b0; bus0.write = 1'b0;
    bus1.chipselect = 1'b0; bus1.write = 1'b0;
    bus2.chipselect = 1'b0; bus2.write = 1'b0;
  endtask

  task automatic bus_write(input int which, input logic [1:0] a, input logic [31:0] d);
    case (which)
      0: begin bus0.chipselect = 1'b1; bus0.write = 1'b1; bus0.address = a; bus0.writedata = d; end
      1: begin bus1.chipselect = 1'b1; bus1.write = 1'b1; bus1.address = a; bus1.writedata = d; end
      default: begin bus2.chipselect = 1'b1; bus2.write = 1'b1; bus2.address = a; bus2.writedata = d; end
    endcase
    step(1);
    bus_idle();
  endtask

  task automatic test_reset();
    step(2);
    n_cmp++; if (bus0.readdata !== 32'h0) begin n_bad++; $display("FAIL reset_rd0: got %h want %h", bus0.readdata, 32'h0); end
    n_cmp++; if (bus1.readdata !== 32'h0) begin n_bad++; $display("FAIL reset_rd1: got %h want %h", bus1.readdata, 32'h0); end
    n_cmp++; if (bus2.readdata !== 32'h0) begin n_bad++; $display("FAIL reset_rd2: got %h want %h", bus2.readdata, 32'h0); end
    n_cmp++; if ({irq0, irq1, irq2} !== 3'b000) begin n_bad++; $display("FAIL reset_irq: got %b want %b", {irq0, irq1, irq2}, 3'b000); end
    // A mask write coinciding with reset must be discarded.
    bus0.chipselect = 1'b1; bus0.write = 1'b1; bus0.address = 2'd2; bus0.writedata = 32'hFF;
    step(1);
    bus_idle();
    reset = 1'b0;
    bus0.address = 2'd2;
    step(2);
    n_cmp++; if (bus0.readdata !== 32'h0) begin n_bad++; $display("FAIL reset_prio_mask: got %h want %h", bus0.readdata, 32'h0); end
  endtask

  task automatic test_data_capture();
    bus0.address = 2'd0;
    in_port0 = 8'h01;
    step(1);
    n_cmp++; if (bus0.readdata !== 32'h0) begin n_bad++; $display("FAIL data_edge1: got %h want %h", bus0.readdata, 32'h0); end
    step(1);
    n_cmp++; if (bus0.readdata !== 32'h0) begin n_bad++; $display("FAIL data_edge2: got %h want %h", bus0.readdata, 32'h0); end
    step(1);
    n_cmp++; if (bus0.readdata !== 32'h1) begin n_bad++; $display("FAIL data_edge3: got %h want %h", bus0.readdata, 32'h1); end
    bus0.address = 2'd3;
    step(1);
    n_cmp++; if (bus0.readdata !== 32'h1) begin n_bad++; $display("FAIL capture_rise: got %h want %h", bus0.readdata, 32'h1); end
    n_cmp++; if (irq0 !== 1'b0) begin n_bad++; $display("FAIL irq_unmasked: got %b want %b", irq0, 1'b0); end
    bus_write(0, 2'd3, 32'h1);
    step(1);
    n_cmp++; if (bus0.readdata !== 32'h0) begin n_bad++; $display("FAIL capture_clear: got %h want %h", bus0.readdata, 32'h0); end
  endtask

  task automatic test_ignored_writes();
    bus_write(0, 2'd0, 32'hFF);
    bus_write(0, 2'd1, 32'hFF);
    bus0.write = 1'b1; bus0.address = 2'd2; bus0.writedata = 32'hFF;  // chipselect stays low
    step(1);
    bus_idle();
    step(1);
    n_cmp++; if (bus0.readdata !== 32'h0) begin n_bad++; $display("FAIL ignored_writes_mask: got %h want %h", bus0.readdata, 32'h0); end
    bus0.address = 2'd1;
    step(1);
    n_cmp++; if (bus0.readdata !== 32'h0) begin n_bad++; $display("FAIL reserved_read: got %h want %h", bus0.readdata, 32'h0); end
    bus_write(0, 2'd2, 32'hFFFF_FF01);
    step(1);
    n_cmp++; if (bus0.readdata !== 32'h1) begin n_bad++; $display("FAIL mask_load_upper_zero: got %h want %h", bus0.readdata, 32'h1); end
  endtask

  task automatic test_irq_edge();
    in_port0 = 8'h00;
    step(4);
    n_cmp++; if (irq0 !== 1'b0) begin n_bad++; $display("FAIL irq_falling_ignored: got %b want %b", irq0, 1'b0); end
    in_port0 = 8'h01;
    step(2);
    n_cmp++; if (irq0 !== 1'b0) begin n_bad++; $display("FAIL irq_edge2: got %b want %b", irq0, 1'b0); end
    step(1);
    n_cmp++; if (irq0 !== 1'b1) begin n_bad++; $display("FAIL irq_edge3: got %b want %b", irq0, 1'b1); end
    bus_write(0, 2'd3, 32'h1);
    n_cmp++; if (irq0 !== 1'b0) begin n_bad++; $display("FAIL irq_after_clear: got %b want %b", irq0, 1'b0); end
    in_port0 = 8'h00;
    step(3);
    in_port0 = 8'h01;
    step(3);
    n_cmp++; if (irq0 !== 1'b1) begin n_bad++; $display("FAIL irq_recapture: got %b want %b", irq0, 1'b1); end
    bus_write(0, 2'd2, 32'h0);
    n_cmp++; if (irq0 !== 1'b0) begin n_bad++; $display("FAIL irq_mask_off: got %b want %b", irq0, 1'b0); end
    bus0.address = 2'd3;
    step(1);
    n_cmp++; if (bus0.readdata !== 32'h1) begin n_bad++; $display("FAIL mask_keeps_capture: got %h want %h", bus0.readdata, 32'h1); end
    bus_write(0, 2'd3, 32'hFF);
  endtask

  task automatic test_set_wins();
    in_port0 = 8'h00;
    step(4);
    in_port0 = 8'h01;
    step(2);
    bus_write(0, 2'd3, 32'h1);  // clear lands on the same edge that captures the new rise
    step(1);
    n_cmp++; if (bus0.readdata !== 32'h1) begin n_bad++; $display("FAIL set_beats_clear: got %h want %h", bus0.readdata, 32'h1); end
    step(1);
    n_cmp++; if (bus0.readdata !== 32'h1) begin n_bad++; $display("FAIL set_persists: got %h want %h", bus0.readdata, 32'h1); end
    bus_write(0, 2'd3, 32'h1);
    step(1);
    n_cmp++; if (bus0.readdata !== 32'h0) begin n_bad++; $display("FAIL clear_after_set: got %h want %h", bus0.readdata, 32'h0); end
  endtask

  task automatic test_any_edge_wide();
    in_port1 = 32'hFFFF_FFFF;
    step(4);
    bus_write(1, 2'd3, 32'hFFFF_FFFF);
    step(1);
    n_cmp++; if (bus1.readdata !== 32'h0) begin n_bad++; $display("FAIL wide_clear_all: got %h want %h", bus1.readdata, 32'h0); end
    in_port1 = 32'h0;
    step(4);
    n_cmp++; if (bus1.readdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wide_fall_capture: got %h want %h", bus1.readdata, 32'hFFFF_FFFF); end
    bus_write(1, 2'd3, 32'h0000_FFFF);
    step(1);
    n_cmp++; if (bus1.readdata !== 32'hFFFF_0000) begin n_bad++; $display("FAIL wide_partial_clear: got %h want %h", bus1.readdata, 32'hFFFF_0000); end
    n_cmp++; if (irq1 !== 1'b0) begin n_bad++; $display("FAIL wide_irq_masked: got %b want %b", irq1, 1'b0); end
    bus1.address = 2'd0;
    step(1);
    n_cmp++; if (bus1.readdata !== 32'h0) begin n_bad++; $display("FAIL wide_data: got %h want %h", bus1.readdata, 32'h0); end
  endtask

  task automatic test_level_irq();
    bus_write(2, 2'd2, 32'h80);
    in_port2 = 8'h80;
    step(1);
    n_cmp++; if (irq2 !== 1'b0) begin n_bad++; $display("FAIL level_edge1: got %b want %b", irq2, 1'b0); end
    step(1);
    n_cmp++; if (irq2 !== 1'b1) begin n_bad++; $display("FAIL level_edge2: got %b want %b", irq2, 1'b1); end
    step(3);
    n_cmp++; if (irq2 !== 1'b1) begin n_bad++; $display("FAIL level_held: got %b want %b", irq2, 1'b1); end
    in_port2 = 8'h00;
    step(1);
    n_cmp++; if (irq2 !== 1'b1) begin n_bad++; $display("FAIL level_release1: got %b want %b", irq2, 1'b1); end
    step(1);
    n_cmp++; if (irq2 !== 1'b0) begin n_bad++; $display("FAIL level_release2: got %b want %b", irq2, 1'b0); end
    in_port2 = 8'h40;
    step(3);
    n_cmp++; if (irq2 !== 1'b0) begin n_bad++; $display("FAIL level_unmasked_bit: got %b want %b", irq2, 1'b0); end
    in_port2 = 8'h00;
    step(2);
  endtask

  task automatic test_reset_mid();
    bus_write(0, 2'd2, 32'h1);
    in_port0 = 8'h00;
    step(3);
    in_port0 = 8'h01;
    step(3);
    n_cmp++; if (irq0 !== 1'b1) begin n_bad++; $display("FAIL pre_reset_irq0: got %b want %b", irq0, 1'b1); end
    in_port2 = 8'h80;
    step(3);
    n_cmp++; if (irq2 !== 1'b1) begin n_bad++; $display("FAIL pre_reset_irq2: got %b want %b", irq2, 1'b1); end
    reset = 1'b1;
    bus2.chipselect = 1'b1; bus2.write = 1'b1; bus2.address = 2'd2; bus2.writedata = 32'hFF;
    step(1);
    bus_idle();
    n_cmp++; if ({irq0, irq2} !== 2'b00) begin n_bad++; $display("FAIL mid_reset_irq: got %b want %b", {irq0, irq2}, 2'b00); end
    n_cmp++; if (bus0.readdata !== 32'h0) begin n_bad++; $display("FAIL mid_reset_rd0: got %h want %h", bus0.readdata, 32'h0); end
    n_cmp++; if (bus2.readdata !== 32'h0) begin n_bad++; $display("FAIL mid_reset_rd2: got %h want %h", bus2.readdata, 32'h0); end
    reset = 1'b0;
    bus0.address = 2'd3;
    bus2.address = 2'd3;
    step(3);
    n_cmp++; if (bus2.readdata !== 32'h0) begin n_bad++; $display("FAIL release_edge3: got %h want %h", bus2.readdata, 32'h0); end
    step(1);
    n_cmp++; if (bus2.readdata !== 32'h80) begin n_bad++; $display("FAIL release_capture2: got %h want %h", bus2.readdata, 32'h80); end
    n_cmp++; if (bus0.readdata !== 32'h1) begin n_bad++; $display("FAIL release_capture0: got %h want %h", bus0.readdata, 32'h1); end
    n_cmp++; if ({irq0, irq2} !== 2'b00) begin n_bad++; $display("FAIL release_irq: got %b want %b", {irq0, irq2}, 2'b00); end
    bus2.address = 2'd2;
    step(1);
    n_cmp++; if (bus2.readdata !== 32'h0) begin n_bad++; $display("FAIL reset_beats_write: got %h want %h", bus2.readdata, 32'h0); end
  endtask

  initial begin
    reset = 1'b1;
    in_port0 = '0; in_port1 = '0; in_port2 = '0;
    bus_idle();
    bus0.address = '0; bus0.writedata = '0;
    bus1.address = '0; bus1.writedata = '0;
    bus2.address = '0; bus2.writedata = '0;
    @(negedge clk);
    test_reset();
    test_data_capture();
    test_ignored_writes();
    test_irq_edge();
    test_set_wins();
    test_any_edge_wide();
    test_level_irq();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
